reg_file_2w2r: RTL and testbench
================================

Name: reg_file_2w2r

Overview:
Parametrised successor to the single-write register file. It holds 2**AW registers of N bits and provides two combinational read ports. It has two independent write ports with per-byte enables, an optional hardwired zero register, and optional same-cycle write-to-read bypass. It sits in the datapath between decode (register addresses) and execute/writeback (busW0 from ALU, busW1 from load unit).

Parameters:
N, 32, data width in bits; must be a multiple of 8
AW, 5, register address width; DEPTH = 2**AW registers
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary
BYPASS, 1, 1 = reads see data being written this cycle; 0 = reads see stored contents only

Ports:
Clock  input  1  single clock; all register updates on rising edge
Reset  input  1  asynchronous, active-high; clears every register to 0
Ra  input  AW  read address, port A
Rb  input  AW  read address, port B
busA  output  N  read data, port A
busB  output  N  read data, port B
Rw0  input  AW  write address, port 0
RegWr0  input  1  write enable, port 0
ByteEn0  input  N/8  byte enables, port 0; bit i covers busW0[8i+7:8i]
busW0  input  N  write data, port 0
Rw1  input  AW  write address, port 1
RegWr1  input  1  write enable, port 1
ByteEn1  input  N/8  byte enables, port 1
busW1  input  N  write data, port 1

Behaviour:
- Reset asserted, asynchronously: all DEPTH registers become 0 and busA/busB read 0 within the same cycle. While Reset is high:
  - writes are ignored;
  - bypass is suppressed;
  - busA = busB = 0.
- Reset deasserted: the first write can occur at the first rising Clock edge where Reset is low.
- Write, rising edge of Clock, port p: if RegWrp = 1, each byte i of mem[Rwp] with ByteEnp[i] = 1 takes busWp byte i. Bytes with ByteEnp[i] = 0 keep their value. RegWrp = 1 with ByteEnp = 0 performs no write.
- Same-address collision (Rw0 == Rw1, both enabled): resolved per byte.
  - Byte enabled on port 1: takes port 1 data.
  - Byte enabled only on port 0: takes port 0 data.
  - Byte enabled on neither: unchanged.
- Different addresses: both writes complete in the same edge.
- ZERO_REG = 1: any write to address 0 is discarded, reads of address 0 return 0, and bypass never applies to address 0.
- Read path is combinational (0-cycle latency from address to data).
  - BYPASS = 0: busX = mem[RX].
  - BYPASS = 1: busX = the value mem[RX] will hold after the current edge. This is the per-byte merge of the stored value, port 0, then port 1, with the collision rule above, applying only to ports whose enabled write address equals RX.
- Net effect with BYPASS = 1: a read issued in the same cycle as a write to the same register returns the new data. With BYPASS = 0 it returns the old data, and the new data appears the cycle after the edge.
- Ra == Rb is legal; both outputs carry identical data.
- Writes and reads to any address 0..DEPTH-1 are valid; there is no out-of-range case.
- No X propagation: registers never hold X after the first Reset.

Test Plan:
- Reset/clear: write 32'hDEADBEEF to r5, pulse Reset for half a cycle between edges, Ra=5 -> busA = 0 immediately, before the next edge.
- Basic write/read: RegWr0=1, Rw0=3, ByteEn0=4'hF, busW0=32'h12345678, edge; then Ra=3, Rb=3 -> busA = busB = 32'h12345678.
- Byte-enable merge: r7 = 32'hAAAAAAAA; RegWr0=1, Rw0=7, ByteEn0=4'b0101, busW0=32'h11223344, edge -> r7 reads 32'hAA22AA44.
- Collision: r9 = 0; same cycle port 0 writes r9 = 32'h01010101 with ByteEn0=4'hF and port 1 writes r9 = 32'h02020202 with ByteEn1=4'b0011 -> r9 = 32'h01010202.
- Bypass: BYPASS=1, r4 = 32'h0; Ra=4, RegWr1=1, Rw1=4, ByteEn1=4'hF, busW1=32'hCAFEF00D -> busA = 32'hCAFEF00D before the edge. Repeat with BYPASS=0 -> busA = 0 before the edge and 32'hCAFEF00D after it.
- Zero register: ZERO_REG=1, write 32'hFFFFFFFF to r0 on both ports with BYPASS=1 -> busA (Ra=0) = 0 before and after the edge. Rerun with ZERO_REG=0 -> r0 reads 32'hFFFFFFFF after the edge.

Source files
------------

// File: rtl/reg_file_2w2r.sv
// Register file: 2**AW x N bits, two byte-enabled write ports, two
// combinational read ports, optional hardwired zero register and optional
// same-cycle write-to-read bypass.
module reg_file_2w2r #(
    parameter int unsigned N        = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [AW-1:0]   Ra,
    input  logic [AW-1:0]   Rb,
    output logic [N-1:0]    busA,
    output logic [N-1:0]    busB,
    input  logic [AW-1:0]   Rw0,
    input  logic            RegWr0,
    input  logic [N/8-1:0]  ByteEn0,
    input  logic [N-1:0]    busW0,
    input  logic [AW-1:0]   Rw1,
    input  logic            RegWr1,
    input  logic [N/8-1:0]  ByteEn1,
    input  logic [N-1:0]    busW1
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned NB    = N / 8;

    logic [N-1:0] mem [DEPTH];

    // Value register 'addr' will hold after this edge: stored bytes, overlaid
    // by port 0, then port 1 (port 1 wins a same-byte collision).
    function automatic logic [N-1:0] merge(input logic [AW-1:0] addr,
                                           input logic [N-1:0]  old);
        logic [N-1:0] res;
        res = old;
        for (int b = 0; b < NB; b++) begin
            if (RegWr0 && (Rw0 == addr) && ByteEn0[b]) begin
                res[b*8 +: 8] = busW0[b*8 +: 8];
            end
            if (RegWr1 && (Rw1 == addr) && ByteEn1[b]) begin
                res[b*8 +: 8] = busW1[b*8 +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Storage update: clear on reset, otherwise apply merged writes per register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (!is_zero_reg(AW'(r))) begin
                    mem[r] <= merge(AW'(r), mem[r]);
                end
            end
        end
    end

    // Read port A: forced to 0 during reset and for the zero register.
    always_comb begin
        busA = '0;
        if (!Reset && !is_zero_reg(Ra)) begin
            busA = (BYPASS != 0) ? merge(Ra, mem[Ra]) : mem[Ra];
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        busB = '0;
        if (!Reset && !is_zero_reg(Rb)) begin
            busB = (BYPASS != 0) ? merge(Rb, mem[Rb]) : mem[Rb];
        end
    end

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Directed bench for reg_file_2w2r. Three instances share all inputs:
// default (zero reg + bypass), no-bypass, and no-zero-reg.
module tb_reg_file_2w2r;

    logic        Clock;
    logic        Reset;
    logic [4:0]  Ra, Rb, Rw0, Rw1;
    logic        RegWr0, RegWr1;
    logic [3:0]  ByteEn0, ByteEn1;
    logic [31:0] busW0, busW1;
    logic [31:0] a_d, b_d, a_nb, b_nb, a_nz, b_nz;

    int pass_cnt  = 0;
    int total_cnt = 0;

    reg_file_2w2r #(.N(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .Clock(Clock), .Reset(Reset), .Ra(Ra), .Rb(Rb), .busA(a_d), .busB(b_d),
        .Rw0(Rw0), .RegWr0(RegWr0), .ByteEn0(ByteEn0), .busW0(busW0),
        .Rw1(Rw1), .RegWr1(RegWr1), .ByteEn1(ByteEn1), .busW1(busW1)
    );

    reg_file_2w2r #(.N(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .Clock(Clock), .Reset(Reset), .Ra(Ra), .Rb(Rb), .busA(a_nb), .busB(b_nb),
        .Rw0(Rw0), .RegWr0(RegWr0), .ByteEn0(ByteEn0), .busW0(busW0),
        .Rw1(Rw1), .RegWr1(RegWr1), .ByteEn1(ByteEn1), .busW1(busW1)
    );

    reg_file_2w2r #(.N(32), .AW(5), .ZERO_REG(0), .BYPASS(1)) dut_nz (
        .Clock(Clock), .Reset(Reset), .Ra(Ra), .Rb(Rb), .busA(a_nz), .busB(b_nz),
        .Rw0(Rw0), .RegWr0(RegWr0), .ByteEn0(ByteEn0), .busW0(busW0),
        .Rw1(Rw1), .RegWr1(RegWr1), .ByteEn1(ByteEn1), .busW1(busW1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
        Rw0 = a; ByteEn0 = be; busW0 = d; RegWr0 = 1'b1;
        tick();
        RegWr0 = 1'b0;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
        Rw1 = a; ByteEn1 = be; busW1 = d; RegWr1 = 1'b1;
        tick();
        RegWr1 = 1'b0;
    endtask

    task automatic test_reset();
        Ra = 5'd5; Rb = 5'd5;
        #1;
        total_cnt++;
        if (a_d !== 32'h0 || b_d !== 32'h0) $display("FAIL reset_init: busA=%h busB=%h want 0", a_d, b_d);
        else pass_cnt++;
        tick();
        Reset = 1'b0;
        tick();
        wr0(5'd5, 4'hF, 32'hDEADBEEF);
        total_cnt++;
        if (a_d !== 32'hDEADBEEF) $display("FAIL reset_prewrite: busA=%h want deadbeef", a_d);
        else pass_cnt++;
        // Mid-cycle reset pulse, entirely between edges.
        #3 Reset = 1'b1;
        #1;
        total_cnt++;
        if (a_d !== 32'h0 || a_nb !== 32'h0 || a_nz !== 32'h0)
            $display("FAIL reset_async: busA=%h/%h/%h want 0", a_d, a_nb, a_nz);
        else pass_cnt++;
        #2 Reset = 1'b0;
        #1;
        total_cnt++;
        if (a_d !== 32'h0 || a_nb !== 32'h0) $display("FAIL reset_cleared: busA=%h/%h want 0", a_d, a_nb);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_basic();
        wr0(5'd3, 4'hF, 32'h12345678);
        Ra = 5'd3; Rb = 5'd3;
        #1;
        total_cnt++;
        if (a_d !== 32'h12345678 || b_d !== 32'h12345678)
            $display("FAIL basic_p0: busA=%h busB=%h want 12345678", a_d, b_d);
        else pass_cnt++;
        wr1(5'd10, 4'hF, 32'h9ABCDEF0);
        Ra = 5'd10; Rb = 5'd3;
        #1;
        total_cnt++;
        if (a_nb !== 32'h9ABCDEF0 || b_nb !== 32'h12345678)
            $display("FAIL basic_p1: busA=%h busB=%h want 9abcdef0/12345678", a_nb, b_nb);
        else pass_cnt++;
    endtask

    task automatic test_byte_en();
        wr0(5'd7, 4'hF, 32'hAAAAAAAA);
        wr0(5'd7, 4'b0101, 32'h11223344);
        Ra = 5'd7;
        #1;
        total_cnt++;
        if (a_nb !== 32'hAA22AA44) $display("FAIL byte_merge: busA=%h want aa22aa44", a_nb);
        else pass_cnt++;
        // Enabled with no bytes, then bytes with no enable: both no-ops.
        wr0(5'd7, 4'b0000, 32'h55555555);
        Rw1 = 5'd7; ByteEn1 = 4'hF; busW1 = 32'h66666666; RegWr1 = 1'b0;
        tick();
        total_cnt++;
        if (a_nb !== 32'hAA22AA44 || a_d !== 32'hAA22AA44)
            $display("FAIL byte_noop: busA=%h/%h want aa22aa44", a_nb, a_d);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        wr0(5'd9, 4'hF, 32'h0);
        Rw0 = 5'd9; ByteEn0 = 4'hF; busW0 = 32'h01010101; RegWr0 = 1'b1;
        Rw1 = 5'd9; ByteEn1 = 4'b0011; busW1 = 32'h02020202; RegWr1 = 1'b1;
        tick();
        RegWr0 = 1'b0; RegWr1 = 1'b0;
        Ra = 5'd9;
        #1;
        total_cnt++;
        if (a_nb !== 32'h01010202) $display("FAIL collision: busA=%h want 01010202", a_nb);
        else pass_cnt++;
        // Different addresses complete on the same edge.
        Rw0 = 5'd11; ByteEn0 = 4'hF; busW0 = 32'h11111111; RegWr0 = 1'b1;
        Rw1 = 5'd12; ByteEn1 = 4'hF; busW1 = 32'h22222222; RegWr1 = 1'b1;
        tick();
        RegWr0 = 1'b0; RegWr1 = 1'b0;
        Ra = 5'd11; Rb = 5'd12;
        #1;
        total_cnt++;
        if (a_nb !== 32'h11111111 || b_nb !== 32'h22222222)
            $display("FAIL dual_write: busA=%h busB=%h want 11111111/22222222", a_nb, b_nb);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        wr0(5'd4, 4'hF, 32'h0);
        Ra = 5'd4;
        Rw1 = 5'd4; ByteEn1 = 4'hF; busW1 = 32'hCAFEF00D; RegWr1 = 1'b1;
        #1;
        total_cnt++;
        if (a_d !== 32'hCAFEF00D) $display("FAIL bypass_on: busA=%h want cafef00d", a_d);
        else pass_cnt++;
        total_cnt++;
        if (a_nb !== 32'h0) $display("FAIL bypass_off_pre: busA=%h want 0", a_nb);
        else pass_cnt++;
        tick();
        RegWr1 = 1'b0;
        total_cnt++;
        if (a_nb !== 32'hCAFEF00D) $display("FAIL bypass_off_post: busA=%h want cafef00d", a_nb);
        else pass_cnt++;
        // Bypass merges per byte with stored r9 = 01010202.
        Rb = 5'd9;
        Rw0 = 5'd9; ByteEn0 = 4'b1000; busW0 = 32'hFF000000; RegWr0 = 1'b1;
        Rw1 = 5'd9; ByteEn1 = 4'b0001; busW1 = 32'h000000EE; RegWr1 = 1'b1;
        #1;
        total_cnt++;
        if (b_d !== 32'hFF0102EE || b_nb !== 32'h01010202)
            $display("FAIL bypass_merge: busB=%h/%h want ff0102ee/01010202", b_d, b_nb);
        else pass_cnt++;
        tick();
        RegWr0 = 1'b0; RegWr1 = 1'b0;
        total_cnt++;
        if (b_nb !== 32'hFF0102EE) $display("FAIL merge_stored: busB=%h want ff0102ee", b_nb);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        Ra = 5'd0; Rb = 5'd0;
        Rw0 = 5'd0; ByteEn0 = 4'hF; busW0 = 32'hFFFFFFFF; RegWr0 = 1'b1;
        Rw1 = 5'd0; ByteEn1 = 4'hF; busW1 = 32'hFFFFFFFF; RegWr1 = 1'b1;
        #1;
        total_cnt++;
        if (a_d !== 32'h0 || a_nz !== 32'hFFFFFFFF)
            $display("FAIL zero_pre: busA=%h/%h want 0/ffffffff", a_d, a_nz);
        else pass_cnt++;
        tick();
        RegWr0 = 1'b0; RegWr1 = 1'b0;
        total_cnt++;
        if (a_d !== 32'h0 || a_nb !== 32'h0 || b_nz !== 32'hFFFFFFFF)
            $display("FAIL zero_post: busA=%h/%h busB=%h want 0/0/ffffffff", a_d, a_nb, b_nz);
        else pass_cnt++;
    endtask

    task automatic test_reset_blocks_write();
        Ra = 5'd3;
        Reset = 1'b1;
        Rw0 = 5'd3; ByteEn0 = 4'hF; busW0 = 32'h77777777; RegWr0 = 1'b1;
        Rw1 = 5'd3; ByteEn1 = 4'hF; busW1 = 32'h88888888; RegWr1 = 1'b1;
        #1;
        total_cnt++;
        if (a_d !== 32'h0) $display("FAIL reset_no_bypass: busA=%h want 0", a_d);
        else pass_cnt++;
        tick();
        RegWr0 = 1'b0; RegWr1 = 1'b0;
        #2 Reset = 1'b0;
        #1;
        total_cnt++;
        if (a_nb !== 32'h0 || a_nz !== 32'h0) $display("FAIL reset_no_write: busA=%h/%h want 0", a_nb, a_nz);
        else pass_cnt++;
        // First edge after reset release accepts writes.
        @(negedge Clock);
        wr1(5'd3, 4'hF, 32'h0BADF00D);
        total_cnt++;
        if (a_nb !== 32'h0BADF00D) $display("FAIL first_write: busA=%h want 0badf00d", a_nb);
        else pass_cnt++;
    endtask

    initial begin
        Reset = 1'b1;
        Ra = '0; Rb = '0; Rw0 = '0; Rw1 = '0;
        RegWr0 = 1'b0; RegWr1 = 1'b0;
        ByteEn0 = '0; ByteEn1 = '0; busW0 = '0; busW1 = '0;
        test_reset();
        test_basic();
        test_byte_en();
        test_collision();
        test_bypass();
        test_zero();
        test_reset_blocks_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
